// File: rtl/reg_pkg.sv
// Shared types and defaults for the registered skid-buffer stage.
package reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/reg_skid_buffer.sv
// Valid/ready register stage with a one-entry skid buffer; the input ready is
// a flop, so a stalling consumer never reaches the producer combinationally.
//
// state | meaning
// EMPTY | no word held
// BUSY  | main_q holds the output word
// FULL  | main_q holds the output word, skid_q holds the next one
module reg_skid_buffer
  import reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        occupancy_o
);

  skid_state_t       state, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid_i & ready_q;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data_i;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so only the drain move can happen
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    occupancy_o = 2'd0;
    case (state)
      BUSY:    occupancy_o = 2'd1;
      FULL:    occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign out_valid_o = (state != EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = ready_q;

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Self-checking bench for reg_skid_buffer against a two-word FIFO queue model.
module tb_reg_skid_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  occupancy;

  int checks = 0;
  int failures = 0;

  // Reference model: words held in arrival order, capacity two, registered ready.
  logic [31:0] mq[$];
  bit          m_ready = 1'b0;
  int          emitted = 0;
  int          accepted = 0;

  reg_skid_buffer #(.DATA_W(32)) dut (
    .clk_i       (clk),
    .arst_i      (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .occupancy_o (occupancy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, sample point +1.
  task automatic drive(input bit vin, input logic [31:0] din, input bit ordy);
    bit in_f, out_f;
    in_valid  = vin;
    in_data   = din;
    out_ready = ordy;
    in_f  = vin && m_ready;
    out_f = ordy && (mq.size() > 0);
    @(posedge clk);
    if (out_f) begin
      void'(mq.pop_front());
      emitted++;
    end
    if (in_f) begin
      mq.push_back(din);
      accepted++;
    end
    m_ready = (mq.size() < 2);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: valid=%b occ=%0d data=%h ready=%b, required 0 0 0 0",
               out_valid, occupancy, out_data, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: got %b, required 0 before first edge", in_ready);
    end
    // Word offered in the first cycle after release must be ignored.
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_edge: ready=%b valid=%b occ=%0d, required 1 0 0",
               in_ready, out_valid, occupancy);
    end
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: valid=%b data=%h occ=%0d ready=%b, required 1 %h 1 1",
                 i, out_valid, out_data, occupancy, in_ready, 32'(i));
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall_skid();
    drive(1'b1, 32'hA, 1'b0);
    checks++;
    if (out_data !== 32'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_a: data=%h occ=%0d ready=%b, required a 1 1", out_data, occupancy, in_ready);
    end
    drive(1'b1, 32'hB, 1'b0);
    checks++;
    if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL skid_b: data=%h occ=%0d ready=%b, required a 2 0", out_data, occupancy, in_ready);
    end
    drive(1'b1, 32'hC, 1'b0);
    checks++;
    if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL skid_c_held: data=%h occ=%0d ready=%b, required a 2 0", out_data, occupancy, in_ready);
    end
    drive(1'b1, 32'hC, 1'b1);
    checks++;
    if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL skid_emit_b: data=%h occ=%0d ready=%b, required b 1 1", out_data, occupancy, in_ready);
    end
    drive(1'b1, 32'hC, 1'b1);
    checks++;
    if (out_data !== 32'hC || occupancy !== 2'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL skid_emit_c: data=%h occ=%0d valid=%b, required c 1 1", out_data, occupancy, out_valid);
    end
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL skid_drain: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stable_hold();
    drive(1'b1, 32'h55AA_55AA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h55AA_55AA || occupancy !== 2'd1) begin
        failures++;
        $display("FAIL hold_%0d: valid=%b data=%h occ=%0d, required 1 55aa55aa 1",
                 i, out_valid, out_data, occupancy);
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL hold_release: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    logic [31:0] word;
    int cycles = 0;
    int target;
    bit r_lo, r_hi;
    accepted = 0;
    emitted  = 0;
    word = $urandom;
    while (accepted < 1000 && cycles < 20000) begin
      bit vin, ordy;
      vin  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      // in_ready must not follow out_ready within the cycle
      out_ready = 1'b0;
      #1 r_lo = in_ready;
      out_ready = 1'b1;
      #1 r_hi = in_ready;
      checks++;
      if (r_lo !== m_ready || r_hi !== m_ready) begin
        failures++;
        $display("FAIL rand_ready_comb cyc %0d: ready(or=0)=%b ready(or=1)=%b, required %b",
                 cycles, r_lo, r_hi, m_ready);
      end
      target = accepted;
      drive(vin, word, ordy);
      if (accepted != target) word = $urandom;
      cycles++;
      checks++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) || in_ready !== m_ready ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        failures++;
        $display("FAIL rand_cyc_%0d: valid=%b occ=%0d ready=%b data=%h, required %b %0d %b %h",
                 cycles, out_valid, occupancy, in_ready, out_data,
                 mq.size() > 0, mq.size(), m_ready, (mq.size() > 0) ? mq[0] : 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (accepted != 1000 || emitted != 1000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_totals: accepted=%0d emitted=%0d valid=%b cycles=%0d, required 1000 1000 0",
               accepted, emitted, out_valid, cycles);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h1, 1'b0);
    drive(1'b1, 32'h2, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || out_data !== 32'h1) begin
      failures++;
      $display("FAIL midrst_full: occ=%0d data=%h, required 2 1", occupancy, out_data);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: valid=%b occ=%0d data=%h ready=%b, required 0 0 0 0",
               out_valid, occupancy, out_data, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h3, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL midrst_first_out: valid=%b data=%h occ=%0d, required 1 3 1",
               out_valid, out_data, occupancy);
    end
    drive(1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL midrst_drain: valid=%b occ=%0d, required 0 0 (stale word after reset)",
               out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_stable_hold();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
